pcie_tx_arb: RTL and testbench

//  Shares the single PCIe core transmit port (tx_req/tx_rdy/tx_st/tx_end/tx_data, 16-bit) between N_SRC TLP sources
//  (e.g. slave completion engine, master/DMA requester). Each source sees a private copy of the core TX handshake.

---
 rtl/pcie_tx_arb.sv | 168 ++++++++++++++++
 tb/tb_pcie_tx_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_arb.sv
// Round-robin arbiter sharing one 16-bit PCIe core TX port among N_SRC TLP sources.
// Optional per-TLP watchdog abort is built when PCIE_TX_ARB_WDOG_EN is defined.
module pcie_tx_arb #(
  parameter int N_SRC       = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 pcie_clk,
  input  logic                 sys_rst_n,
  input  logic [N_SRC-1:0]     src_req,
  output logic [N_SRC-1:0]     src_rdy,
  input  logic [N_SRC-1:0]     src_st,
  input  logic [N_SRC-1:0]     src_end,
  input  logic [16*N_SRC-1:0]  src_data,
  output logic [N_SRC-1:0]     src_abort,
  output logic                 tx_req,
  input  logic                 tx_rdy,
  output logic                 tx_st,
  output logic                 tx_end,
  output logic [15:0]          tx_data,
  output logic [1:0]           arb_owner,
  output logic                 arb_busy,
  output logic                 wdog_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

  state_t      state_q, state_d;
  logic        tx_req_q, tx_req_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  owner_q, owner_d;

  logic [N_SRC-1:0] owner_oh;
  logic             own_req, own_st, own_end;
  logic [15:0]      own_data;
  logic [1:0]       pick;
  logic [1:0]       owner_plus1;
  logic             wdog_fire;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_owner_oh
      assign owner_oh[gi] = (owner_q == 2'(gi));
    end
  endgenerate

  assign own_req = |(src_req & owner_oh);
  assign own_st  = |(src_st  & owner_oh);
  assign own_end = |(src_end & owner_oh);

  always_comb begin
    own_data = 16'h0;
    for (int i = 0; i < N_SRC; i++) begin
      if (owner_oh[i]) own_data = src_data[16*i +: 16];
    end
  end

  // Scan from the highest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_ptr_q;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      for (int j = 0; j < N_SRC; j++) begin
        if (j == idx && src_req[j]) pick = 2'(j);
      end
    end
  end

  assign owner_plus1 = (owner_q == 2'(N_SRC - 1)) ? 2'd0 : owner_q + 2'd1;

`ifdef PCIE_TX_ARB_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;

  // A same-cycle src_end always takes precedence over the watchdog.
  assign wdog_fire = (state_q == ST_XFER) && !own_end &&
                     (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q | wdog_fire;
    if (state_q == ST_REQ && tx_rdy) begin
      wdog_cnt_d = '0;
    end else if (state_q == ST_XFER && !own_end) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  assign wdog_err  = wdog_err_q;
  assign src_abort = wdog_fire ? owner_oh : '0;
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES != 0);
  assign wdog_fire   = 1'b0;
  assign wdog_err    = 1'b0;
  assign src_abort   = '0;
`endif

  always_comb begin
    state_d  = state_q;
    tx_req_d = tx_req_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (|src_req) begin
          owner_d  = pick;
          tx_req_d = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_rdy) begin
          tx_req_d = 1'b0;
          state_d  = ST_XFER;
        end else if (!own_req) begin
          tx_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (own_end || wdog_fire) begin
          rr_ptr_d = owner_plus1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        tx_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      tx_req_q   <= 1'b0;
      rr_ptr_q   <= 2'd0;
      owner_q    <= 2'd0;
`ifdef PCIE_TX_ARB_WDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
`ifdef PCIE_TX_ARB_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign src_rdy   = (state_q == ST_REQ && tx_rdy) ? owner_oh : '0;
  assign tx_req    = tx_req_q;
  assign tx_st     = (state_q == ST_XFER) && own_st;
  assign tx_end    = (state_q == ST_XFER) && (own_end || wdog_fire);
  assign tx_data   = (state_q == ST_XFER && !wdog_fire) ? own_data : 16'h0;
  assign arb_owner = owner_q;
  assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Scoreboard bench for pcie_tx_arb: stimulus pushes expected grants/beats, a negedge monitor pops and compares.
module tb_pcie_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  src_req, src_rdy, src_st, src_end, src_abort;
  logic [31:0] src_data;
  logic        tx_req, tx_rdy, tx_st, tx_end;
  logic [15:0] tx_data;
  logic [1:0]  arb_owner;
  logic        arb_busy, wdog_err;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    bit          grant;
    logic [15:0] a;
    logic [1:0]  b;
  } item_t;
  item_t exp_q[$];
  item_t mon_got, mon_exp;
  bit    mon_ev;

  always #5 clk = ~clk;

  pcie_tx_arb #(.N_SRC(2), .WDOG_CYCLES(16)) dut (
    .pcie_clk (clk),
    .sys_rst_n(rst_n),
    .src_req  (src_req),
    .src_rdy  (src_rdy),
    .src_st   (src_st),
    .src_end  (src_end),
    .src_data (src_data),
    .src_abort(src_abort),
    .tx_req   (tx_req),
    .tx_rdy   (tx_rdy),
    .tx_st    (tx_st),
    .tx_end   (tx_end),
    .tx_data  (tx_data),
    .arb_owner(arb_owner),
    .arb_busy (arb_busy),
    .wdog_err (wdog_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a grant strobe or any visible TX beat is one transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ev = 1'b0;
      if (src_rdy != 2'b00) begin
        mon_got.grant = 1'b1; mon_got.a = {14'h0, src_rdy}; mon_got.b = arb_owner; mon_ev = 1'b1;
      end else if (tx_st || tx_end || tx_data != 16'h0) begin
        mon_got.grant = 1'b0; mon_got.a = tx_data; mon_got.b = {tx_st, tx_end}; mon_ev = 1'b1;
      end
      if (mon_ev) begin
        $display("txn %s a=%h b=%b t=%0t", mon_got.grant ? "grant" : "beat ", mon_got.a, mon_got.b, $time);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_txn: got a=%h b=%b expected none", mon_got.a, mon_got.b);
        end else begin
          mon_exp = exp_q.pop_front();
          chk(mon_exp.grant ? "grant" : "beat",
              {13'h0, mon_got.grant, mon_got.b, mon_got.a},
              {13'h0, mon_exp.grant, mon_exp.b, mon_exp.a});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] dval(input int s, input int tag, input int b);
    return {4'(s + 1), 4'(tag), 8'(b + 1)};
  endfunction

  task automatic drive_idle;
    src_st   = 2'b00;
    src_end  = 2'b00;
    src_data = {16'hBEEF, 16'hCAFE};
  endtask

  task automatic push_grant(input int s);
    exp_q.push_back('{1'b1, 16'(1 << s), 2'(s)});
  endtask

  task automatic push_beat(input int s, input int tag, input int b, input int n);
    exp_q.push_back('{1'b0, dval(s, tag, b), {b == 0, b == n - 1}});
  endtask

  task automatic push_tlp(input int s, input int tag, input int n);
    push_grant(s);
    for (int b = 0; b < n; b++) push_beat(s, tag, b, n);
  endtask

  task automatic wait_req;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_req === 1'b1) return;
    end
    checks++; failures++;
    $display("FAIL tx_req_timeout: got tx_req=%b expected 1 within 20 cycles", tx_req);
  endtask

  task automatic grant(input int delay, output int who);
    wait_req();
    for (int i = 0; i < delay; i++) tick();
    tx_rdy = 1'b1;
    @(negedge clk);
    who = (src_rdy == 2'b10) ? 1 : 0;
  endtask

  task automatic drive_beat(input int s, input int tag, input int b, input int n, input bit do_end);
    tick();
    tx_rdy = 1'b0;
    drive_idle();
    src_st[s]            = (b == 0);
    src_end[s]           = do_end && (b == n - 1);
    src_data[16*s +: 16] = dval(s, tag, b);
  endtask

  task automatic send(input int s, input int tag, input int n, input bit do_end, input bit drop);
    for (int b = 0; b < n; b++) begin
      drive_beat(s, tag, b, n, do_end);
      if (drop && b == 0) src_req[s] = 1'b0;
      @(negedge clk);
      chk("no_abort", {30'h0, src_abort}, 32'h0);
      chk("tx_req_low_xfer", {31'h0, tx_req}, 32'h0);
    end
  endtask

  task automatic finish_tlp;
    tick();
    tx_rdy = 1'b0;
    drive_idle();
    @(negedge clk);
    chk("idle_after_end", {31'h0, arb_busy}, 32'h0);
    chk("tx_data_idle", {16'h0, tx_data}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int who;
    rst_n   = 1'b0;
    src_req = 2'b00;
    tx_rdy  = 1'b0;
    drive_idle();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tx_req", {31'h0, tx_req}, 32'h0);
    chk("rst_busy", {31'h0, arb_busy}, 32'h0);
    chk("rst_src_rdy", {30'h0, src_rdy}, 32'h0);
    chk("rst_owner", {30'h0, arb_owner}, 32'h0);
    chk("rst_tx_data", {16'h0, tx_data}, 32'h0);
    chk("rst_wdog_err", {31'h0, wdog_err}, 32'h0);
    chk("rst_abort", {30'h0, src_abort}, 32'h0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // tx_rdy while idle must be ignored
    tick();
    tx_rdy = 1'b1;
    @(negedge clk);
    chk("idle_rdy_ignored", {30'h0, src_rdy}, 32'h0);
    chk("idle_rdy_busy", {31'h0, arb_busy}, 32'h0);

    // Single src0, 8-beat TLP, tx_rdy two cycles after tx_req
    push_tlp(0, 1, 8);
    tick();
    tx_rdy  = 1'b0;
    src_req = 2'b01;
    @(negedge clk);
    chk("tx_req_cycle_n", {31'h0, tx_req}, 32'h0);
    tick();
    @(negedge clk);
    chk("tx_req_cycle_n1", {31'h0, tx_req}, 32'h1);
    chk("busy_req", {31'h0, arb_busy}, 32'h1);
    tick();
    tick();
    tx_rdy = 1'b1;
    @(negedge clk);
    send(0, 1, 8, 1'b1, 1'b1);
    finish_tlp();

    // src1 withdraws while in REQ; rr_ptr must stay at 1
    tick();
    src_req = 2'b10;
    wait_req();
    tick();
    src_req = 2'b00;
    @(negedge clk);
    chk("withdraw_tx_req_hold", {31'h0, tx_req}, 32'h1);
    chk("withdraw_no_rdy", {30'h0, src_rdy}, 32'h0);
    tick();
    @(negedge clk);
    chk("withdraw_tx_req_fall", {31'h0, tx_req}, 32'h0);
    chk("withdraw_idle", {31'h0, arb_busy}, 32'h0);
    push_tlp(1, 2, 3);
    src_req = 2'b11;
    grant(1, who);
    send(who, 2, 3, 1'b1, 1'b1);
    finish_tlp();

    // Continuous requests from both: strict alternation starting at 0
    for (int t = 0; t < 6; t++) begin
      push_tlp(t % 2, 3 + t, 2 + t);
      src_req = 2'b11;
      grant(1, who);
      send(who, 3 + t, 2 + t, 1'b1, 1'b0);
      finish_tlp();
    end
    src_req = 2'b00;

    // src0 TLP moves rr_ptr to 1, then reset src1 mid-TLP
    push_tlp(0, 9, 2);
    tick();
    src_req = 2'b01;
    grant(1, who);
    send(who, 9, 2, 1'b1, 1'b1);
    finish_tlp();
    push_grant(1);
    for (int b = 0; b < 3; b++) push_beat(1, 10, b, 6);
    src_req = 2'b10;
    grant(1, who);
    for (int b = 0; b < 3; b++) begin
      drive_beat(1, 10, b, 6, 1'b1);
      if (b == 0) src_req = 2'b00;
      if (b == 2) rst_n = 1'b0;
      @(negedge clk);
    end
    tick();
    drive_idle();
    @(negedge clk);
    chk("rst_mid_tx_req", {31'h0, tx_req}, 32'h0);
    chk("rst_mid_tx_st", {31'h0, tx_st}, 32'h0);
    chk("rst_mid_tx_end", {31'h0, tx_end}, 32'h0);
    chk("rst_mid_busy", {31'h0, arb_busy}, 32'h0);
    chk("rst_mid_owner", {30'h0, arb_owner}, 32'h0);
    chk("rst_mid_abort", {30'h0, src_abort}, 32'h0);
    tick();
    rst_n = 1'b1;
    // rr_ptr back at 0: src0 wins against src1
    push_tlp(0, 11, 2);
    src_req = 2'b11;
    grant(1, who);
    send(who, 11, 2, 1'b1, 1'b1);
    src_req = 2'b00;
    finish_tlp();

`ifdef PCIE_TX_ARB_WDOG_EN
    // src_end on exactly the 16th XFER cycle completes normally
    push_tlp(1, 12, 16);
    src_req = 2'b10;
    grant(1, who);
    send(who, 12, 16, 1'b1, 1'b1);
    finish_tlp();
    chk("wdog_err_clean", {31'h0, wdog_err}, 32'h0);

    // Owner never ends: forced end with zero data on 16th cycle
    push_grant(0);
    for (int b = 0; b < 15; b++) push_beat(0, 13, b, 16);
    exp_q.push_back('{1'b0, 16'h0, 2'b01});
    src_req = 2'b01;
    grant(1, who);
    send(who, 13, 15, 1'b0, 1'b1);
    drive_beat(0, 13, 15, 16, 1'b0);
    @(negedge clk);
    chk("wdog_abort_pulse", {30'h0, src_abort}, 32'h1);
    tick();
    drive_idle();
    @(negedge clk);
    chk("wdog_abort_clear", {30'h0, src_abort}, 32'h0);
    chk("wdog_err_set", {31'h0, wdog_err}, 32'h1);
    chk("wdog_idle", {31'h0, arb_busy}, 32'h0);
    tick();
    @(negedge clk);
    chk("wdog_err_sticky", {31'h0, wdog_err}, 32'h1);
`else
    chk("wdog_err_off", {31'h0, wdog_err}, 32'h0);
`endif

    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
